stack_alu_8: RTL

Stack-machine execute stage for the 8-bit processor core. It accepts one stack command at a time from the decoder, pops operands from the 8-bit × 1024 data stack, computes an 8-bit result and pushes it back. It sits directly on the stack's push/pop port as that port's only driver.

---
 rtl/stack_alu_8.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/stack_alu_8.sv
// Stack-machine execute stage: pops operands from the data stack, computes an 8-bit result, pushes it back.
// Optional feature: define STACK_ALU_MUL_EN to enable opcode 11 (MUL, low byte of A*B).
module stack_alu_8 (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CMD_VALID,
    output logic       CMD_READY,
    input  logic [3:0] CMD_OP,
    input  logic [7:0] CMD_IMM,
    output logic       DONE,
    output logic       ERR,
    output logic [1:0] ERR_CODE,
    output logic [7:0] LAST_RESULT,
    input  logic       ST_FULL,
    input  logic       ST_EMPTY,
    output logic       ST_PUSH_VALID,
    output logic [7:0] ST_PUSH_DATA,
    output logic       ST_POP_EN,
    input  logic       ST_POP_VALID,
    input  logic [7:0] ST_POP_DATA
);

    localparam logic [3:0] OP_PUSHI = 4'd0;
    localparam logic [3:0] OP_POP   = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_EQ    = 4'd7;
    localparam logic [3:0] OP_LT    = 4'd8;
    localparam logic [3:0] OP_NOT   = 4'd9;
    localparam logic [3:0] OP_DUP   = 4'd10;
    localparam logic [3:0] OP_MUL   = 4'd11;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_UNDERFLOW = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW  = 2'd2;
    localparam logic [1:0] ERR_ILLEGAL   = 2'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP_B = 3'd1,
        POP_A = 3'd2,
        PUSH  = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] op_q, op_d;
    logic [7:0] imm_q, imm_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [1:0] err_code_q, err_code_d;
    logic [7:0] last_result_q, last_result_d;
    logic [7:0] result;
    logic       op_legal;

`ifdef STACK_ALU_MUL_EN
    logic [15:0] mul_full;
    assign mul_full = {8'd0, a_q} * {8'd0, b_q};
`endif

    always_comb begin
        op_legal = 1'b0;
        if (CMD_OP <= OP_DUP) begin
            op_legal = 1'b1;
        end
`ifdef STACK_ALU_MUL_EN
        if (CMD_OP == OP_MUL) begin
            op_legal = 1'b1;
        end
`endif
    end

    // Result is a pure function of the captured command and latched operands.
    always_comb begin
        result = 8'd0;
        case (op_q)
            OP_PUSHI: result = imm_q;
            OP_ADD:   result = a_q + b_q;
            OP_SUB:   result = a_q - b_q;
            OP_AND:   result = a_q & b_q;
            OP_OR:    result = a_q | b_q;
            OP_XOR:   result = a_q ^ b_q;
            OP_EQ:    result = {7'd0, (a_q == b_q)};
            OP_LT:    result = {7'd0, (a_q < b_q)};
            OP_NOT:   result = ~b_q;
            OP_DUP:   result = b_q;
`ifdef STACK_ALU_MUL_EN
            OP_MUL:   result = mul_full[7:0];
`endif
            default:  result = 8'd0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        imm_d         = imm_q;
        a_d           = a_q;
        b_d           = b_q;
        err_code_d    = err_code_q;
        last_result_d = last_result_q;
        CMD_READY     = 1'b0;
        DONE          = 1'b0;
        ERR           = 1'b0;
        ST_PUSH_VALID = 1'b0;
        ST_POP_EN     = 1'b0;

        case (state_q)
            IDLE: begin
                CMD_READY = 1'b1;
                if (CMD_VALID) begin
                    op_d  = CMD_OP;
                    imm_d = CMD_IMM;
                    if (!op_legal) begin
                        state_d    = FIN;
                        err_code_d = ERR_ILLEGAL;
                    end else if (CMD_OP == OP_PUSHI) begin
                        state_d = PUSH;
                    end else if (CMD_OP == OP_DUP) begin
                        // DUP reads the top without popping it.
                        if (ST_EMPTY) begin
                            state_d    = FIN;
                            err_code_d = ERR_UNDERFLOW;
                        end else begin
                            b_d     = ST_POP_DATA;
                            state_d = PUSH;
                        end
                    end else begin
                        state_d = POP_B;
                    end
                end
            end
            POP_B: begin
                ST_POP_EN = 1'b1;
                if (ST_POP_VALID) begin
                    b_d = ST_POP_DATA;
                    if (op_q == OP_POP) begin
                        state_d    = FIN;
                        err_code_d = ERR_NONE;
                    end else if (op_q == OP_NOT) begin
                        state_d = PUSH;
                    end else begin
                        state_d = POP_A;
                    end
                end else begin
                    state_d    = FIN;
                    err_code_d = ERR_UNDERFLOW;
                end
            end
            POP_A: begin
                ST_POP_EN = 1'b1;
                if (ST_POP_VALID) begin
                    a_d     = ST_POP_DATA;
                    state_d = PUSH;
                end else begin
                    state_d    = FIN;
                    err_code_d = ERR_UNDERFLOW;
                end
            end
            PUSH: begin
                state_d = FIN;
                if (!ST_FULL) begin
                    ST_PUSH_VALID = 1'b1;
                    last_result_d = result;
                    err_code_d    = ERR_NONE;
                end else begin
                    err_code_d = ERR_OVERFLOW;
                end
            end
            FIN: begin
                DONE    = 1'b1;
                ERR     = (err_code_q != ERR_NONE);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            op_q          <= 4'd0;
            imm_q         <= 8'd0;
            a_q           <= 8'd0;
            b_q           <= 8'd0;
            err_code_q    <= ERR_NONE;
            last_result_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            imm_q         <= imm_d;
            a_q           <= a_d;
            b_q           <= b_d;
            err_code_q    <= err_code_d;
            last_result_q <= last_result_d;
        end
    end

    // The error code register is written on entry to FIN, so it reads the new code during DONE and holds after.
    assign ERR_CODE     = err_code_q;
    assign LAST_RESULT  = last_result_q;
    assign ST_PUSH_DATA = result;

endmodule
